// File: rtl/branch_result_merger.sv
// branch_result_merger
// Collects results from all instruction branches and releases them into a
// single registered writeback slot in strict commit_id order.
// Optional feature: define MERGER_TIMEOUT_EN to build a stall watchdog that
// skips a lost commit id after timeout_cycles and raises sticky stall_error.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Upstream branch i transfers when in_valid[i] & in_ready[i];
// in_ready never depends on anything but current inputs and registered state,
// and a branch must hold its fields stable while in_valid[i] & ~in_ready[i].
// Downstream transfers when out_valid & out_ready (gated by enable); the
// output fields stay stable while out_valid & ~out_ready.

`ifndef N_INSTR_BRANCHES
`define N_INSTR_BRANCHES 4
`endif

module branch_result_merger #(
    parameter int  data_width     = 16,
    parameter int  n_branches     = `N_INSTR_BRANCHES,
    parameter int  n_blocks       = 256,
    parameter int  timeout_cycles = 1024,
    localparam int bw             = $clog2(n_blocks)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic [n_branches-1:0]          in_valid,
    output logic [n_branches-1:0]          in_ready,
    input  logic [n_branches*bw-1:0]       block_in,
    input  logic [n_branches*4-1:0]        dest_in,
    input  logic [n_branches*data_width-1:0] result_in,
    input  logic [n_branches*8-1:0]        res_addr_in,
    input  logic [n_branches-1:0]          writes_external_in,
    input  logic [n_branches*9-1:0]        commit_id_in,
    input  logic [n_branches-1:0]          commit_flag_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [bw-1:0]                  block_out,
    output logic [3:0]                     dest_out,
    output logic signed [data_width-1:0]   result_out,
    output logic [7:0]                     res_addr_out,
    output logic                           writes_external_out,
    output logic [8:0]                     commit_id_out,
    output logic                           commit_flag_out,
    output logic [8:0]                     expected_id,
    output logic                           stall_error
);

    localparam int sw = (n_branches > 1) ? $clog2(n_branches) : 1;

    logic [n_branches-1:0]         match;
    logic                          any_match;
    logic [sw-1:0]                 sel;
    logic [bw-1:0]                 nxt_block;
    logic [3:0]                    nxt_dest;
    logic signed [data_width-1:0]  nxt_result;
    logic [7:0]                    nxt_res_addr;
    logic                          nxt_ext;
    logic [8:0]                    nxt_commit_id;
    logic                          nxt_flag;
    logic                          slot_free;
    logic                          capture;
    logic                          drain;
    logic                          timeout_fire;
    logic                          id_advance;

    // Eligibility: only a result carrying the id currently due may leave its branch.
    always_comb begin
        match = '0;
        for (int i = 0; i < n_branches; i++) begin
            match[i] = in_valid[i] & (commit_id_in[i*9 +: 9] == expected_id);
        end
    end

    assign any_match = |match;

    // Fixed priority: the lowest matching branch index wins and its fields are muxed out.
    always_comb begin
        sel           = '0;
        nxt_block     = '0;
        nxt_dest      = '0;
        nxt_result    = '0;
        nxt_res_addr  = '0;
        nxt_ext       = 1'b0;
        nxt_commit_id = '0;
        nxt_flag      = 1'b0;
        for (int i = n_branches - 1; i >= 0; i--) begin
            if (match[i]) begin
                sel           = sw'(i);
                nxt_block     = block_in[i*bw +: bw];
                nxt_dest      = dest_in[i*4 +: 4];
                nxt_result    = result_in[i*data_width +: data_width];
                nxt_res_addr  = res_addr_in[i*8 +: 8];
                nxt_ext       = writes_external_in[i];
                nxt_commit_id = commit_id_in[i*9 +: 9];
                nxt_flag      = commit_flag_in[i];
            end
        end
    end

    assign slot_free  = ~out_valid | out_ready;
    assign capture    = enable & slot_free & any_match;
    assign drain      = enable & out_valid & out_ready;
    assign id_advance = (capture & nxt_flag) | timeout_fire;

    // One-hot accept towards the winning branch; forced low while reset is held.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < n_branches; i++) begin
            in_ready[i] = capture & ~reset & (sel == sw'(i));
        end
    end

`ifdef MERGER_TIMEOUT_EN
    localparam int cw = $clog2(timeout_cycles + 1);

    logic [cw-1:0] stall_cnt;
    logic          stall_flag;
    logic          stalling;

    assign stalling     = |in_valid & ~any_match;
    assign timeout_fire = enable & stalling & (stall_cnt == cw'(timeout_cycles - 1));
    assign stall_error  = stall_flag;

    // Watchdog: counts cycles where results wait but none carries the due id.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt  <= '0;
            stall_flag <= 1'b0;
        end else if (enable) begin
            if (capture || (in_valid == '0) || timeout_fire) begin
                stall_cnt <= '0;
            end else if (stalling) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (timeout_fire) begin
                stall_flag <= 1'b1;
            end
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign stall_error  = 1'b0;
`endif

    // Output slot and commit pointer: capture refills (even while draining), drain empties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid           <= 1'b0;
            block_out           <= '0;
            dest_out            <= '0;
            result_out          <= '0;
            res_addr_out        <= '0;
            writes_external_out <= 1'b0;
            commit_id_out       <= '0;
            commit_flag_out     <= 1'b0;
            expected_id         <= '0;
        end else begin
            if (capture) begin
                out_valid           <= 1'b1;
                block_out           <= nxt_block;
                dest_out            <= nxt_dest;
                result_out          <= nxt_result;
                res_addr_out        <= nxt_res_addr;
                writes_external_out <= nxt_ext;
                commit_id_out       <= nxt_commit_id;
                commit_flag_out     <= nxt_flag;
            end else if (drain) begin
                out_valid <= 1'b0;
            end
            if (id_advance) begin
                expected_id <= expected_id + 9'd1;
            end
        end
    end

endmodule
